// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: one full-adder cell, IDLE/RUN/DONE handshake.
// Optional signed-overflow output enabled by defining SERIAL_ADD_OVF_EN.
module serial_add_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin_i,
  input  logic             ack_i,
  output logic             ready_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] sum_o,
  output logic             cout_o
`ifdef SERIAL_ADD_OVF_EN
  ,
  output logic             ovf_o
`endif
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sr, b_sr, sum_sr, sum_nxt;
  logic [CNT_W-1:0] cnt_q;
  logic             carry_q;
  logic             s_bit, c_bit;
  logic             accept, last_bit;

  assign accept   = (state_q == IDLE) && start_i;
  assign last_bit = (state_q == RUN) && (cnt_q == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start_i)         state_d = RUN;
      RUN:     if (cnt_q == LAST)   state_d = DONE;
      DONE:    if (ack_i)           state_d = IDLE;
      default:                      state_d = IDLE;
    endcase
  end

  always_comb begin
    ready_o = (state_q == IDLE);
    busy_o  = (state_q == RUN);
    done_o  = (state_q == DONE);
    sum_o   = sum_sr;
    cout_o  = carry_q;
  end

  // Single full-adder cell working on the operand LSBs.
  always_comb begin
    s_bit = a_sr[0] ^ b_sr[0] ^ carry_q;
    c_bit = (a_sr[0] & b_sr[0]) | (a_sr[0] & carry_q) | (b_sr[0] & carry_q);
  end

  // Sum bits enter at the MSB so the LSB lands at bit 0 after WIDTH shifts.
  always_comb begin
    sum_nxt            = sum_sr >> 1;
    sum_nxt[WIDTH-1]   = s_bit;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr    <= '0;
      b_sr    <= '0;
      sum_sr  <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
    end else if (accept) begin
      a_sr    <= a_i;
      b_sr    <= b_i;
      sum_sr  <= '0;
      carry_q <= cin_i;
      cnt_q   <= '0;
    end else if (state_q == RUN) begin
      a_sr    <= a_sr >> 1;
      b_sr    <= b_sr >> 1;
      sum_sr  <= sum_nxt;
      carry_q <= c_bit;
      if (!last_bit) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

`ifdef SERIAL_ADD_OVF_EN
  logic ovf_q;

  // Carry into the MSB is carry_q while the last bit is processed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        ovf_q <= 1'b0;
    else if (accept)   ovf_q <= 1'b0;
    else if (last_bit) ovf_q <= carry_q ^ c_bit;
  end

  always_comb ovf_o = ovf_q;
`endif

endmodule

// File: doc/serial_add_ctrl.md
SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001 Parameter WIDTH, default 8, is the operand width in bits; legal range 1..32.
REQ-002 Port clk, input, 1, the single clock; all state SHALL update on its rising edge.
REQ-003 Port rst_n, input, 1, reset; asynchronous assert, active-low.
REQ-004 Port start_i, input, 1, operation request; accepted only when ready_o=1.
REQ-005 Port a_i, input, WIDTH, operand A; sampled at acceptance only.
REQ-006 Port b_i, input, WIDTH, operand B; sampled at acceptance only.
REQ-007 Port cin_i, input, 1, carry-in; sampled at acceptance only.
REQ-008 Port ack_i, input, 1, result acknowledge; honoured only when done_o=1.
REQ-009 Port ready_o, output, 1, high in IDLE only.
REQ-010 Port busy_o, output, 1, high in RUN only.
REQ-011 Port done_o, output, 1, result valid; high in DONE only.
REQ-012 Port sum_o, output, WIDTH, registered sum; valid while done_o=1.
REQ-013 Port cout_o, output, 1, registered final carry; valid while done_o=1.
REQ-014 Port ovf_o, output, 1, signed overflow; present only with SERIAL_ADD_OVF_EN.

Function
REQ-015 The block SHALL be a bit-serial adder with one internal full-adder cell: sum bit = a^b^c; carry = majority(a,b,c).
REQ-016 FSM states SHALL be IDLE, RUN and DONE; encoding is free.
REQ-017 IDLE->RUN SHALL occur on start_i=1. At this edge a_i and b_i SHALL load into shift registers, cin_i into the carry flop, and the bit counter SHALL clear to 0.
REQ-018 Each RUN cycle SHALL process the LSB of each operand register. The sum bit SHALL shift into the MSB of the sum register, the carry flop SHALL take the cell carry, the operands SHALL shift right, and the counter SHALL increment.
REQ-019 RUN->DONE SHALL occur on the edge that processes bit WIDTH-1. done_o SHALL therefore rise exactly WIDTH cycles after the accepting edge.
REQ-020 In DONE, sum_o and cout_o SHALL hold stable until ack_i=1. DONE->IDLE SHALL occur on the edge where ack_i=1.
REQ-021 start_i SHALL be ignored in RUN and DONE, including start_i and ack_i both high in DONE. The result is not disturbed, and a new start needs ready_o=1.
REQ-022 ack_i SHALL be ignored in IDLE and RUN.
REQ-023 Operand inputs SHALL be don't-care except at the accepting edge.
REQ-024 WIDTH=1 SHALL work: RUN lasts one cycle.
REQ-025 The counter SHALL be wide enough to hold WIDTH-1. It SHALL never wrap within an operation.
REQ-026 sum_o SHALL equal (a_i + b_i + cin_i) mod 2^WIDTH. cout_o SHALL equal bit WIDTH of that sum.

Reset
REQ-027 When rst_n=0, the FSM SHALL go to IDLE immediately without waiting for clk, and the counter, carry, operand and sum registers SHALL clear.
REQ-028 Output values during and after reset SHALL be: ready_o=1, busy_o=0, done_o=0, sum_o=0, cout_o=0, ovf_o=0.
REQ-029 A reset asserted mid-RUN or in DONE SHALL abort the operation. No done_o pulse SHALL follow deassertion.
REQ-030 Release of rst_n SHALL be synchronous to clk. The first start SHALL be accepted no earlier than the first rising edge after release.

Configuration
REQ-031 The macro SERIAL_ADD_OVF_EN SHALL control the overflow feature.
REQ-032 With SERIAL_ADD_OVF_EN defined, the ovf_o port and its logic SHALL be present. ovf_o SHALL equal the XOR of the carry into bit WIDTH-1 and the carry out of bit WIDTH-1. It SHALL be registered with the final bit and valid with done_o.
REQ-033 Without SERIAL_ADD_OVF_EN, ovf_o SHALL be absent from the port list and no overflow logic SHALL be generated. All other behaviour SHALL be identical.

Verification (WIDTH=8)
REQ-034 a=0xFF, b=0x01, cin=0 -> done_o at edge 8 after acceptance; sum_o=0x00, cout_o=1, ovf_o=0.
REQ-035 a=0x3C, b=0x5A, cin=1 -> sum_o=0x97, cout_o=0; with the macro, ovf_o=1.
REQ-036 a=0x7F, b=0x01, cin=0 with the macro -> sum_o=0x80, cout_o=0, ovf_o=1. a=0x80, b=0x80 -> sum_o=0x00, cout_o=1, ovf_o=1.
REQ-037 start_i pulsed at RUN cycle 3 with different operands -> ignored; the first result is unchanged. In DONE with start_i and ack_i both high -> IDLE, ready_o=1, no new operation.
REQ-038 rst_n low at RUN cycle 4 -> outputs immediately at reset values. After release, a fresh 0x01+0x01 -> sum_o=0x02 in 8 cycles.
REQ-039 ack_i held low for 20 cycles in DONE -> sum_o and done_o stable throughout. ack_i pulsed in IDLE -> no state change.
